// File: rtl/inst_router_rr_buffered_pkg.sv
// Shared micro-architecture types for the instruction router: uop encoding,
// ISA subset vectors, the subset test and the round-robin pick helper.
package inst_router_rr_buffered_pkg;

  typedef enum logic [3:0] {
    OP_ADD, OP_ADDI, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT, OP_MUL,
    OP_DIV, OP_LW, OP_SW, OP_JAL, OP_JR, OP_BNE, OP_CSRR, OP_CSRW
  } rv_uop;

  localparam int unsigned NUM_OPS   = 16;
  localparam int unsigned MAX_PIPES = 8;

  typedef logic [NUM_OPS-1:0] rv_op_vec;

  localparam rv_op_vec OP_ALU_VEC  = (rv_op_vec'(1) << OP_ADD) | (rv_op_vec'(1) << OP_ADDI) |
                                     (rv_op_vec'(1) << OP_SUB) | (rv_op_vec'(1) << OP_AND)  |
                                     (rv_op_vec'(1) << OP_OR)  | (rv_op_vec'(1) << OP_XOR)  |
                                     (rv_op_vec'(1) << OP_SLT);
  localparam rv_op_vec OP_MUL_VEC  = rv_op_vec'(1) << OP_MUL;
  localparam rv_op_vec OP_DIV_VEC  = rv_op_vec'(1) << OP_DIV;
  localparam rv_op_vec OP_MEM_VEC  = (rv_op_vec'(1) << OP_LW) | (rv_op_vec'(1) << OP_SW);
  localparam rv_op_vec OP_CTRL_VEC = (rv_op_vec'(1) << OP_JAL) | (rv_op_vec'(1) << OP_JR) |
                                     (rv_op_vec'(1) << OP_BNE);
  localparam rv_op_vec OP_CSR_VEC  = (rv_op_vec'(1) << OP_CSRR) | (rv_op_vec'(1) << OP_CSRW);

  // TinyRV1 has no divide and only the basic add/addi forms of the ALU ops.
  localparam rv_op_vec p_tinyrv1 = (rv_op_vec'(1) << OP_ADD) | (rv_op_vec'(1) << OP_ADDI) |
                                   OP_MUL_VEC | OP_MEM_VEC | OP_CTRL_VEC | OP_CSR_VEC;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } rr_grant_t;

  function automatic logic in_subset(input rv_uop op, input rv_op_vec subset);
    return subset[op];
  endfunction

  // First set bit of elig scanning ptr, ptr+1, ... with wrap at num_pipes.
  function automatic rr_grant_t rr_pick(input logic [MAX_PIPES-1:0] elig,
                                        input logic [2:0]           ptr,
                                        input int unsigned          num_pipes);
    rr_grant_t   grant;
    int unsigned k;
    grant = '0;
    for (int unsigned i = 0; i < MAX_PIPES; i++) begin
      k = 32'(ptr) + i;
      if (k >= num_pipes) k = k - num_pipes;
      if (i < num_pipes && !grant.found && elig[k[2:0]]) begin
        grant.found = 1'b1;
        grant.idx   = k[2:0];
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/inst_router_rr_buffered_slot.sv
// One execute pipe's capability decode plus its one-entry registered output slot.
module inst_router_slot
  import inst_router_rr_buffered_pkg::*;
#(
  parameter int unsigned p_payload_bits = 128,
  parameter int unsigned p_seq_num_bits = 5,
  parameter rv_op_vec    p_subset       = p_tinyrv1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      squash,
  input  logic                      load,
  input  rv_uop                     uop,
  input  logic [p_payload_bits-1:0] payload,
  input  logic [p_seq_num_bits-1:0] seq_num,
  output logic                      ex_val,
  input  logic                      ex_rdy,
  output rv_uop                     ex_uop,
  output logic [p_payload_bits-1:0] ex_payload,
  output logic [p_seq_num_bits-1:0] ex_seq_num,
  output logic                      cap,
  output logic                      free
);

  logic                      val_q, val_d;
  rv_uop                     uop_q, uop_d;
  logic [p_payload_bits-1:0] payload_q, payload_d;
  logic [p_seq_num_bits-1:0] seq_num_q, seq_num_d;

  always_comb begin
    cap       = in_subset(uop, p_subset);
    free      = !val_q || (ex_rdy && val_q);
    val_d     = val_q;
    uop_d     = uop_q;
    payload_d = payload_q;
    seq_num_d = seq_num_q;
    if (load) begin
      val_d     = 1'b1;
      uop_d     = uop;
      payload_d = payload;
      seq_num_d = seq_num;
    end else if (val_q && ex_rdy) begin
      val_d = 1'b0;
    end
    // A drain in the squash cycle still completes; whatever remains is dropped.
    if (squash) val_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) val_q <= 1'b0;
    else     val_q <= val_d;
  end

  always_ff @(posedge clk) begin
    uop_q     <= uop_d;
    payload_q <= payload_d;
    seq_num_q <= seq_num_d;
  end

  assign ex_val     = val_q;
  assign ex_uop     = uop_q;
  assign ex_payload = payload_q;
  assign ex_seq_num = seq_num_q;

endmodule

// File: rtl/inst_router_rr_buffered.sv
// Round-robin decode-to-execute router with a registered slot per pipe.
// Define INST_ROUTER_STATS_EN to add dispatch/stall/squash statistics counters.
module inst_router_rr_buffered
  import inst_router_rr_buffered_pkg::*;
#(
  parameter int unsigned p_num_pipes    = 3,
  parameter int unsigned p_payload_bits = 128,
  parameter int unsigned p_seq_num_bits = 5,
  parameter rv_op_vec    p_pipe_subsets [p_num_pipes] = '{default: p_tinyrv1}
) (
  input  logic                      clk,
  input  logic                      rst,
  input  rv_uop                     uop,
  input  logic [p_payload_bits-1:0] payload,
  input  logic [p_seq_num_bits-1:0] seq_num,
  input  logic                      val,
  output logic                      rdy,
  input  logic                      squash,
  output logic [p_num_pipes-1:0]    ex_val,
  input  logic [p_num_pipes-1:0]    ex_rdy,
  output rv_uop                     ex_uop     [p_num_pipes],
  output logic [p_payload_bits-1:0] ex_payload [p_num_pipes],
  output logic [p_seq_num_bits-1:0] ex_seq_num [p_num_pipes],
  output logic                      err_unsupported
`ifdef INST_ROUTER_STATS_EN
  ,
  output logic [31:0]               stat_dispatch [p_num_pipes],
  output logic [31:0]               stat_stall,
  output logic [31:0]               stat_squashed
`endif
);

  logic [p_num_pipes-1:0] cap, free, elig, load;
  logic                   any_cap, xfer;
  rr_grant_t              pick;
  logic [2:0]             ptr_q, ptr_d;
  logic                   err_q, err_d;

  for (genvar i = 0; i < p_num_pipes; i++) begin : g_slot
    inst_router_slot #(
      .p_payload_bits(p_payload_bits),
      .p_seq_num_bits(p_seq_num_bits),
      .p_subset      (p_pipe_subsets[i])
    ) u_slot (
      .clk       (clk),
      .rst       (rst),
      .squash    (squash),
      .load      (load[i]),
      .uop       (uop),
      .payload   (payload),
      .seq_num   (seq_num),
      .ex_val    (ex_val[i]),
      .ex_rdy    (ex_rdy[i]),
      .ex_uop    (ex_uop[i]),
      .ex_payload(ex_payload[i]),
      .ex_seq_num(ex_seq_num[i]),
      .cap       (cap[i]),
      .free      (free[i])
    );
  end

  // A uop no pipe supports is still accepted so decode never deadlocks on it.
  always_comb begin
    any_cap = |cap;
    elig    = cap & free;
    rdy     = !squash && (|elig || !any_cap);
    xfer    = val && rdy;
    pick    = rr_pick(MAX_PIPES'(elig), ptr_q, p_num_pipes);
    load    = '0;
    for (int unsigned i = 0; i < p_num_pipes; i++) begin
      load[i] = xfer && pick.found && (32'(pick.idx) == i);
    end
    ptr_d = ptr_q;
    if (xfer && pick.found) begin
      if (pick.idx == 3'(p_num_pipes - 1)) ptr_d = '0;
      else                                 ptr_d = pick.idx + 3'd1;
    end
    err_d = xfer && !any_cap;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
      err_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      err_q <= err_d;
    end
  end

  assign err_unsupported = err_q;

`ifdef INST_ROUTER_STATS_EN
  logic [31:0]            stat_dispatch_q [p_num_pipes];
  logic [31:0]            stat_dispatch_d [p_num_pipes];
  logic [31:0]            stat_stall_q, stat_stall_d;
  logic [31:0]            stat_squashed_q, stat_squashed_d;
  logic [p_num_pipes-1:0] squash_drop;

  // Only slots that are not draining this cycle count as discarded by a squash.
  always_comb begin
    squash_drop     = squash ? (ex_val & ~ex_rdy) : '0;
    stat_stall_d    = stat_stall_q + 32'(val && !rdy && !squash);
    stat_squashed_d = stat_squashed_q + 32'($countones(squash_drop));
    for (int unsigned i = 0; i < p_num_pipes; i++) begin
      stat_dispatch_d[i] = stat_dispatch_q[i] + 32'(load[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_stall_q    <= '0;
      stat_squashed_q <= '0;
      for (int unsigned i = 0; i < p_num_pipes; i++) stat_dispatch_q[i] <= '0;
    end else begin
      stat_stall_q    <= stat_stall_d;
      stat_squashed_q <= stat_squashed_d;
      for (int unsigned i = 0; i < p_num_pipes; i++) stat_dispatch_q[i] <= stat_dispatch_d[i];
    end
  end

  assign stat_dispatch = stat_dispatch_q;
  assign stat_stall    = stat_stall_q;
  assign stat_squashed = stat_squashed_q;
`endif

endmodule

// File: tb/tb_inst_router_rr_buffered.sv
// Bench for inst_router_rr_buffered: two instances (uniform TinyRV1 pipes and
// ALU/MUL/ALU+MEM pipes) checked every cycle against a queue-level model.
module tb_inst_router_rr_buffered;
  import inst_router_rr_buffered_pkg::*;

  localparam int N  = 3;
  localparam int PB = 128;
  localparam int SB = 5;
  localparam rv_op_vec SUB_B [N] = '{OP_ALU_VEC, OP_MUL_VEC, OP_ALU_VEC | OP_MEM_VEC};

  logic          clk, rst, val, squash;
  rv_uop         uop;
  logic [PB-1:0] payload;
  logic [SB-1:0] seq_num;
  logic [N-1:0]  ex_rdy;

  logic          rdy_a, err_a, rdy_b, err_b;
  logic [N-1:0]  ex_val_a, ex_val_b;
  rv_uop         ex_uop_a [N], ex_uop_b [N];
  logic [PB-1:0] ex_pay_a [N], ex_pay_b [N];
  logic [SB-1:0] ex_seq_a [N], ex_seq_b [N];
`ifdef INST_ROUTER_STATS_EN
  logic [31:0]   st_disp_a [N], st_disp_b [N];
  logic [31:0]   st_stall_a, st_stall_b, st_sq_a, st_sq_b;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  bit checking = 0;

  inst_router_rr_buffered #(.p_num_pipes(N), .p_payload_bits(PB), .p_seq_num_bits(SB)) dut_a (
    .clk(clk), .rst(rst), .uop(uop), .payload(payload), .seq_num(seq_num), .val(val),
    .rdy(rdy_a), .squash(squash), .ex_val(ex_val_a), .ex_rdy(ex_rdy), .ex_uop(ex_uop_a),
    .ex_payload(ex_pay_a), .ex_seq_num(ex_seq_a), .err_unsupported(err_a)
`ifdef INST_ROUTER_STATS_EN
    , .stat_dispatch(st_disp_a), .stat_stall(st_stall_a), .stat_squashed(st_sq_a)
`endif
  );

  inst_router_rr_buffered #(.p_num_pipes(N), .p_payload_bits(PB), .p_seq_num_bits(SB),
                            .p_pipe_subsets(SUB_B)) dut_b (
    .clk(clk), .rst(rst), .uop(uop), .payload(payload), .seq_num(seq_num), .val(val),
    .rdy(rdy_b), .squash(squash), .ex_val(ex_val_b), .ex_rdy(ex_rdy), .ex_uop(ex_uop_b),
    .ex_payload(ex_pay_b), .ex_seq_num(ex_seq_b), .err_unsupported(err_b)
`ifdef INST_ROUTER_STATS_EN
    , .stat_dispatch(st_disp_b), .stat_stall(st_stall_b), .stat_squashed(st_sq_b)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: per instance, a full flag and contents per pipe plus the rotation start.
  rv_op_vec      m_sub  [2][N];
  bit            m_full [2][N];
  rv_uop         m_uop  [2][N];
  logic [PB-1:0] m_pay  [2][N];
  logic [SB-1:0] m_seq  [2][N];
  int            m_ptr  [2];
  bit            m_err  [2];

  function automatic bit m_cap(int d, int i);
    return m_sub[d][i][uop];
  endfunction

  function automatic bit m_any_cap(int d);
    for (int i = 0; i < N; i++) if (m_cap(d, i)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int m_grant(int d);
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_ptr[d] + k) % N;
      if (m_cap(d, i) && (!m_full[d][i] || ex_rdy[i])) return i;
    end
    return -1;
  endfunction

  function automatic bit m_rdy(int d);
    return !squash && (m_grant(d) >= 0 || !m_any_cap(d));
  endfunction

  initial begin
    for (int i = 0; i < N; i++) begin
      m_sub[0][i] = p_tinyrv1;
      m_sub[1][i] = SUB_B[i];
    end
    forever begin
      @(posedge clk);
      for (int d = 0; d < 2; d++) begin
        if (rst) begin
          for (int i = 0; i < N; i++) m_full[d][i] = 1'b0;
          m_ptr[d] = 0;
          m_err[d] = 1'b0;
        end else begin
          int g;
          bit take;
          g    = m_grant(d);
          take = val && m_rdy(d);
          m_err[d] = take && !m_any_cap(d);
          for (int i = 0; i < N; i++) if (m_full[d][i] && ex_rdy[i]) m_full[d][i] = 1'b0;
          if (squash) begin
            for (int i = 0; i < N; i++) m_full[d][i] = 1'b0;
          end else if (take && g >= 0) begin
            m_full[d][g] = 1'b1;
            m_uop[d][g]  = uop;
            m_pay[d][g]  = payload;
            m_seq[d][g]  = seq_num;
            m_ptr[d]     = (g + 1) % N;
          end
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] required);
    n_checks++;
    if (actual === required) n_pass++;
    else $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, required);
  endtask

  // Per-cycle comparison of both instances against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (checking) begin
        for (int d = 0; d < 2; d++) begin
          logic         r, e;
          logic [N-1:0] v, mv;
          r = (d == 0) ? rdy_a : rdy_b;
          e = (d == 0) ? err_a : err_b;
          v = (d == 0) ? ex_val_a : ex_val_b;
          for (int i = 0; i < N; i++) mv[i] = m_full[d][i];
          checkOutput($sformatf("model dut%0d rdy", d), 128'(r), 128'(m_rdy(d)));
          checkOutput($sformatf("model dut%0d ex_val", d), 128'(v), 128'(mv));
          checkOutput($sformatf("model dut%0d err", d), 128'(e), 128'(m_err[d]));
          for (int i = 0; i < N; i++) begin
            if (m_full[d][i]) begin
              rv_uop         uo;
              logic [PB-1:0] pa;
              logic [SB-1:0] sq;
              uo = (d == 0) ? ex_uop_a[i] : ex_uop_b[i];
              pa = (d == 0) ? ex_pay_a[i] : ex_pay_b[i];
              sq = (d == 0) ? ex_seq_a[i] : ex_seq_b[i];
              checkOutput($sformatf("model dut%0d uop[%0d]", d, i), 128'(uo), 128'(m_uop[d][i]));
              checkOutput($sformatf("model dut%0d payload[%0d]", d, i), pa, m_pay[d][i]);
              checkOutput($sformatf("model dut%0d seq[%0d]", d, i), 128'(sq), 128'(m_seq[d][i]));
            end
          end
        end
      end
    end
  end

  task automatic applyStimulus(input bit v, input rv_uop op, input int s, input bit sq, input logic [N-1:0] er);
    val     = v;
    uop     = op;
    seq_num = SB'(s);
    payload = {4{32'h9E37_79B9 * 32'(s + 1)}};
    squash  = sq;
    ex_rdy  = er;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  rv_uop        flt_ops [4] = '{OP_MUL, OP_LW, OP_ADD, OP_ADD};
  logic [N-1:0] flt_exp [4] = '{3'b010, 3'b100, 3'b001, 3'b100};

  initial begin
    rst = 1'b1;
    applyStimulus(0, OP_ADD, 0, 0, '0);
    tick();
    checking = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checkOutput("reset ex_val", 128'(ex_val_a), 128'(3'b000));
    checkOutput("reset err", 128'(err_a), 128'(0));
    checkOutput("reset rdy", 128'(rdy_a), 128'(1));

    // Round-robin over identical pipes.
    for (int s = 0; s < 6; s++) begin
      applyStimulus(1, OP_ADD, s, 0, 3'b111);
      #1 checkOutput("rr rdy", 128'(rdy_a), 128'(1));
      tick();
      checkOutput("rr ex_val", 128'(ex_val_a), 128'(3'b001 << (s % 3)));
      checkOutput("rr seq", 128'(ex_seq_a[s % 3]), 128'(s));
    end
    applyStimulus(0, OP_ADD, 0, 0, 3'b111);
    tick();
    checkOutput("rr drained", 128'(ex_val_a), 128'(3'b000));

    // Subset filtering on the ALU/MUL/ALU+MEM instance.
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1, flt_ops[k], 6 + k, 0, 3'b111);
      tick();
      checkOutput("subset ex_val", 128'(ex_val_b), 128'(flt_exp[k]));
      if (k == 0) checkOutput("subset mul uop", 128'(ex_uop_b[1]), 128'(OP_MUL));
    end
    applyStimulus(0, OP_ADD, 0, 0, 3'b111);
    tick();

    // Backpressure: fill, stall, then same-cycle drain and reload of pipe1.
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, OP_ADD, 10 + k, 0, 3'b000);
      tick();
    end
    checkOutput("bp full", 128'(ex_val_a), 128'(3'b111));
    applyStimulus(1, OP_ADD, 13, 0, 3'b000);
    #1 checkOutput("bp stall rdy", 128'(rdy_a), 128'(0));
    tick();
    applyStimulus(1, OP_ADD, 13, 0, 3'b010);
    #1 checkOutput("bp drain rdy", 128'(rdy_a), 128'(1));
    tick();
    checkOutput("bp reload ex_val", 128'(ex_val_a), 128'(3'b111));
    checkOutput("bp reload seq", 128'(ex_seq_a[1]), 128'(13));

    // Squash with pipes 0 and 2 full.
    applyStimulus(0, OP_ADD, 0, 0, 3'b010);
    tick();
    checkOutput("sq pre ex_val", 128'(ex_val_a), 128'(3'b101));
    checkOutput("sq pre ex_val b", 128'(ex_val_b), 128'(3'b101));
    applyStimulus(1, OP_ADD, 14, 1, 3'b000);
    #1 checkOutput("sq rdy", 128'(rdy_a), 128'(0));
    checkOutput("sq rdy b", 128'(rdy_b), 128'(0));
    tick();
    checkOutput("sq ex_val", 128'(ex_val_a), 128'(3'b000));
    checkOutput("sq ex_val b", 128'(ex_val_b), 128'(3'b000));
    applyStimulus(1, OP_ADD, 15, 0, 3'b111);
    tick();
    checkOutput("sq ptr kept", 128'(ex_val_a), 128'(3'b100));
    checkOutput("sq ptr kept b", 128'(ex_val_b), 128'(3'b001));

    // Unsupported uop.
    applyStimulus(1, OP_DIV, 16, 0, 3'b000);
    #1 checkOutput("unsup rdy", 128'(rdy_a), 128'(1));
    tick();
    checkOutput("unsup err", 128'(err_a), 128'(1));
    checkOutput("unsup err b", 128'(err_b), 128'(1));
    checkOutput("unsup ex_val", 128'(ex_val_a), 128'(3'b100));
    applyStimulus(0, OP_DIV, 17, 0, 3'b000);
    tick();
    checkOutput("unsup err pulse", 128'(err_a), 128'(0));
    applyStimulus(1, OP_ADD, 18, 0, 3'b000);
    tick();
    checkOutput("unsup ptr kept", 128'(ex_val_a), 128'(3'b101));
    checkOutput("unsup ptr kept b", 128'(ex_val_b), 128'(3'b101));

    // Reset while slots are full and a transfer is in progress.
    applyStimulus(1, OP_ADD, 19, 0, 3'b000);
    rst = 1'b1;
    #1 checkOutput("rst xfer rdy", 128'(rdy_a), 128'(1));
    tick();
    rst = 1'b0;
    checkOutput("rst ex_val", 128'(ex_val_a), 128'(3'b000));
    checkOutput("rst err", 128'(err_a), 128'(0));
`ifdef INST_ROUTER_STATS_EN
    checkOutput("rst stat_stall", 128'(st_stall_a), 128'(0));
    checkOutput("rst stat_squashed", 128'(st_sq_a), 128'(0));
    for (int i = 0; i < N; i++) checkOutput("rst stat_dispatch", 128'(st_disp_a[i]), 128'(0));
`endif
    applyStimulus(1, OP_ADD, 20, 0, 3'b111);
    tick();
    checkOutput("rst ptr zero", 128'(ex_val_a), 128'(3'b001));
    checkOutput("rst ptr zero b", 128'(ex_val_b), 128'(3'b001));
`ifdef INST_ROUTER_STATS_EN
    checkOutput("stat_dispatch after reset", 128'(st_disp_a[0]), 128'(1));
`endif
    applyStimulus(0, OP_ADD, 0, 0, 3'b111);
    tick();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
